// File: rtl/twos_comp_arbiter.sv
// Round-robin arbiter sharing one two's complement negator between NUM_REQ requesters.
// Optional macro TWOS_COMP_ARB_OVF_EN adds rsp_ovf, flagging negation of the most-negative operand.
module twos_comp_arbiter #(
    parameter int SIZE    = 8,
    parameter int NUM_REQ = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*SIZE-1:0] req_data,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [SIZE-1:0]         rsp_data,
    output logic [1:0]              rsp_id
`ifdef TWOS_COMP_ARB_OVF_EN
   ,output logic                    rsp_ovf
`endif
);

    generate
        if (NUM_REQ < 2 || NUM_REQ > 4) begin : g_bad_num_req
            $error("twos_comp_arbiter: NUM_REQ must be in 2..4");
        end
        if (SIZE < 2) begin : g_bad_size
            $error("twos_comp_arbiter: SIZE must be >= 2");
        end
    endgenerate

    localparam int IW = (NUM_REQ > 2) ? 2 : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                 state_q, state_d;
    logic [SIZE-1:0]        op_q;
    logic [1:0]             id_q;
    logic [1:0]             last_q;
    logic [NUM_REQ-1:0]     grant;
    logic [1:0]             grant_idx;
    logic                   grant_found;
    logic [IW-1:0]          idx;
    logic                   accept;
`ifdef TWOS_COMP_ARB_OVF_EN
    logic                   ovf_q;
`endif

    // Search starts just past the last winner and wraps, so the last winner has lowest priority.
    always_comb begin
        grant       = '0;
        grant_idx   = last_q;
        grant_found = 1'b0;
        idx         = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = IW'((int'(last_q) + k) % NUM_REQ);
            if (!grant_found && req_valid[idx]) begin
                grant[idx]  = 1'b1;
                grant_idx   = 2'(idx);
                grant_found = 1'b1;
            end
        end
    end

    assign accept = (state_q == IDLE) && grant_found;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = BUSY;
            BUSY:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        rsp_valid = 1'b0;
        rsp_data  = '0;
        case (state_q)
            IDLE: req_ready = grant;
            BUSY: begin
                rsp_valid = 1'b1;
                rsp_data  = ~op_q + SIZE'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= '0;
            id_q   <= '0;
            last_q <= 2'(NUM_REQ - 1);
        end else if (accept) begin
            op_q   <= req_data[int'(grant_idx)*SIZE +: SIZE];
            id_q   <= grant_idx;
            last_q <= grant_idx;
        end
    end

    assign rsp_id = id_q;

`ifdef TWOS_COMP_ARB_OVF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (accept) begin
            ovf_q <= (req_data[int'(grant_idx)*SIZE +: SIZE] == {1'b1, {(SIZE-1){1'b0}}});
        end
    end

    assign rsp_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_twos_comp_arbiter.sv
// Scoreboard bench for twos_comp_arbiter (SIZE=8, NUM_REQ=2); checks rsp_ovf when TWOS_COMP_ARB_OVF_EN is set.
module tb_twos_comp_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [15:0] req_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_data;
    logic [1:0]  rsp_id;
`ifdef TWOS_COMP_ARB_OVF_EN
    logic        rsp_ovf;
`endif

    twos_comp_arbiter #(.SIZE(8), .NUM_REQ(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id)
`ifdef TWOS_COMP_ARB_OVF_EN
       ,.rsp_ovf   (rsp_ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] id;
        logic [7:0] data;
        logic       ovf;
    } exp_t;

    exp_t       sb[$];
    int         vectors     = 0;
    int         miscompares = 0;
    logic       m_busy;
    logic [1:0] m_last;

    function automatic logic [1:0] exp_grant(input logic [1:0] v, input logic [1:0] last);
        if (last == 2'd0) begin
            if (v[1]) return 2'b10;
            if (v[0]) return 2'b01;
        end else begin
            if (v[0]) return 2'b01;
            if (v[1]) return 2'b10;
        end
        return 2'b00;
    endfunction

    // Advances the reference model across the coming rising edge; pushes the expected response on accept.
    task automatic model_step();
        logic [1:0] g;
        logic [7:0] op;
        exp_t       e;
        if (!m_busy) begin
            g = exp_grant(req_valid, m_last);
            if (g != 2'b00) begin
                op     = g[1] ? req_data[15:8] : req_data[7:0];
                e.id   = {1'b0, g[1]};
                e.data = 8'(0 - int'(op));
                e.ovf  = (op == 8'h80);
                sb.push_back(e);
                m_last = {1'b0, g[1]};
                m_busy = 1'b1;
            end
        end else if (rsp_ready) begin
            m_busy = 1'b0;
        end
    endtask

    task automatic model_reset();
        sb.delete();
        m_busy = 1'b0;
        m_last = 2'd1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 2'b00; req_data = '0; rsp_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        vectors++;
        if ({rsp_valid, rsp_data, rsp_id, req_ready} !== 13'd0) begin
            miscompares++;
            $display("FAIL reset: valid=%b data=%h id=%0d ready=%b, required all zero",
                     rsp_valid, rsp_data, rsp_id, req_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        exp_t e;
        logic [1:0] g;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            req_data  = 16'h0004;
            req_valid = (c == 0) ? 2'b01 : 2'b00;
            rsp_ready = (c != 0);
            #1;
            g = m_busy ? 2'b00 : exp_grant(req_valid, m_last);
            vectors++;
            if ({req_ready, rsp_valid} !== {g, m_busy}) begin
                miscompares++;
                $display("FAIL single_hs c%0d: ready=%b valid=%b, required ready=%b valid=%b",
                         c, req_ready, rsp_valid, g, m_busy);
            end
            if (c == 0) begin
                vectors++;
                if (req_ready !== 2'b01) begin
                    miscompares++;
                    $display("FAIL single_grant: ready=%b, required 01", req_ready);
                end
            end
            if (m_busy && rsp_ready) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL single_sb: response with empty scoreboard");
                end else begin
                    e = sb.pop_front();
                    if ({rsp_id, rsp_data} !== {e.id, e.data} || {rsp_id, rsp_data} !== {2'd0, 8'hFC}) begin
                        miscompares++;
                        $display("FAIL single_rsp: id=%0d data=%h, required id=0 data=fc", rsp_id, rsp_data);
                    end
                end
            end
            model_step();
        end
    endtask

    task automatic test_fairness();
        exp_t e;
        logic [1:0] g;
        int n = 0;
        @(negedge clk);
        rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            req_valid = 2'b11; req_data = {8'h06, 8'h01}; rsp_ready = 1'b1;
            #1;
            g = m_busy ? 2'b00 : exp_grant(req_valid, m_last);
            vectors++;
            if ({req_ready, rsp_valid} !== {g, m_busy}) begin
                miscompares++;
                $display("FAIL fair_hs c%0d: ready=%b valid=%b, required ready=%b valid=%b",
                         c, req_ready, rsp_valid, g, m_busy);
            end
            if (m_busy && rsp_ready) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL fair_sb: response with empty scoreboard");
                end else begin
                    e = sb.pop_front();
                    if ({rsp_id, rsp_data} !== {e.id, e.data} || rsp_id !== 2'(n % 2) ||
                        rsp_data !== ((n % 2 == 0) ? 8'hFF : 8'hFA)) begin
                        miscompares++;
                        $display("FAIL fair_rsp n%0d: id=%0d data=%h, required id=%0d data=%h",
                                 n, rsp_id, rsp_data, n % 2, (n % 2 == 0) ? 8'hFF : 8'hFA);
                    end
                end
                n++;
            end
            model_step();
        end
        vectors++;
        if (n != 8) begin
            miscompares++;
            $display("FAIL fair_count: %0d results in 16 cycles, required 8", n);
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        logic [1:0] g;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            req_data  = {8'h33, 8'h07};
            req_valid = (c == 0) ? 2'b01 : (c < 4) ? 2'b11 : 2'b00;
            rsp_ready = (c >= 4);
            #1;
            g = m_busy ? 2'b00 : exp_grant(req_valid, m_last);
            vectors++;
            if ({req_ready, rsp_valid} !== {g, m_busy}) begin
                miscompares++;
                $display("FAIL bp_hs c%0d: ready=%b valid=%b, required ready=%b valid=%b",
                         c, req_ready, rsp_valid, g, m_busy);
            end
            if (c >= 1 && c <= 3) begin
                vectors++;
                if ({rsp_valid, rsp_id, rsp_data, req_ready} !== {1'b1, 2'd0, 8'hF9, 2'b00}) begin
                    miscompares++;
                    $display("FAIL bp_hold c%0d: valid=%b id=%0d data=%h ready=%b, required 1/0/f9/00",
                             c, rsp_valid, rsp_id, rsp_data, req_ready);
                end
            end
            if (c == 5) begin
                vectors++;
                if (rsp_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL bp_release: rsp_valid=%b, required 0", rsp_valid);
                end
            end
            if (m_busy && rsp_ready) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL bp_sb: response with empty scoreboard");
                end else begin
                    e = sb.pop_front();
                    if ({rsp_id, rsp_data} !== {e.id, e.data}) begin
                        miscompares++;
                        $display("FAIL bp_rsp: id=%0d data=%h, required id=%0d data=%h",
                                 rsp_id, rsp_data, e.id, e.data);
                    end
                end
            end
            model_step();
        end
    endtask

    task automatic test_boundaries();
        logic [7:0] ops [5]  = '{8'h00, 8'h80, 8'h7F, 8'hFF, 8'h01};
        logic [7:0] res [5]  = '{8'h00, 8'h80, 8'h81, 8'h01, 8'hFF};
        logic       ovfs [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        exp_t e;
        logic [1:0] g;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            req_data  = {ops[c/2], ops[c/2]};
            req_valid = (c % 2 == 1) ? 2'b00 : ((c / 2) % 2 == 0) ? 2'b01 : 2'b10;
            rsp_ready = 1'b1;
            #1;
            g = m_busy ? 2'b00 : exp_grant(req_valid, m_last);
            vectors++;
            if ({req_ready, rsp_valid} !== {g, m_busy}) begin
                miscompares++;
                $display("FAIL bound_hs c%0d: ready=%b valid=%b, required ready=%b valid=%b",
                         c, req_ready, rsp_valid, g, m_busy);
            end
            if (m_busy && rsp_ready) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL bound_sb: response with empty scoreboard");
                end else begin
                    e = sb.pop_front();
                    if ({rsp_id, rsp_data} !== {e.id, e.data} || rsp_data !== res[c/2]) begin
                        miscompares++;
                        $display("FAIL bound_rsp op=%h: id=%0d data=%h, required id=%0d data=%h",
                                 ops[c/2], rsp_id, rsp_data, e.id, res[c/2]);
                    end
`ifdef TWOS_COMP_ARB_OVF_EN
                    vectors++;
                    if (rsp_ovf !== ovfs[c/2] || rsp_ovf !== e.ovf) begin
                        miscompares++;
                        $display("FAIL bound_ovf op=%h: ovf=%b, required %b", ops[c/2], rsp_ovf, ovfs[c/2]);
                    end
`endif
                end
            end
            model_step();
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        logic [1:0] g;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            req_data  = (c < 2) ? 16'h0010 : {8'h22, 8'h11};
            req_valid = (c == 0) ? 2'b01 : (c == 5) ? 2'b11 : 2'b00;
            rsp_ready = (c >= 2);
            #1;
            g = m_busy ? 2'b00 : exp_grant(req_valid, m_last);
            vectors++;
            if ({req_ready, rsp_valid} !== {g, m_busy}) begin
                miscompares++;
                $display("FAIL rmid_hs c%0d: ready=%b valid=%b, required ready=%b valid=%b",
                         c, req_ready, rsp_valid, g, m_busy);
            end
            if (c == 5) begin
                vectors++;
                if (req_ready !== 2'b01) begin
                    miscompares++;
                    $display("FAIL rmid_regrant: ready=%b, required 01", req_ready);
                end
            end
            if (m_busy && rsp_ready) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL rmid_sb: response with empty scoreboard");
                end else begin
                    e = sb.pop_front();
                    if ({rsp_id, rsp_data} !== {e.id, e.data} || {rsp_id, rsp_data} !== {2'd0, 8'hEF}) begin
                        miscompares++;
                        $display("FAIL rmid_rsp: id=%0d data=%h, required id=0 data=ef", rsp_id, rsp_data);
                    end
                end
            end
            model_step();
            if (c == 1) begin
                #2;
                rst_n = 1'b0;
                #1;
                vectors++;
                if ({rsp_valid, rsp_data} !== 9'd0) begin
                    miscompares++;
                    $display("FAIL rmid_async: valid=%b data=%h, required 0/00", rsp_valid, rsp_data);
                end
                model_reset();
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_boundaries();
        test_reset_mid();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL sb_drain: %0d responses never produced, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
